// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate-extension unit.
// Extends an IN_WIDTH immediate to OUT_WIDTH (sign / zero / upper / shift2)
// behind a registered valid/ready output stage with a one-entry skid buffer.
// The registers are cleared by asynchronous active-high reset. flush
// synchronously drops every held entry.
// Optional feature macro: IMM_EXT_SHIFT2_EN. When it is defined, mode 2'b11 is
// the sign-extended immediate shifted left by two (branch byte offset).
// Otherwise mode 2'b11 aliases sign extension and no shifter is built.
module imm_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_imm,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_imm
);

    localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

    // Extension function, applied to the input side only
    function automatic logic [OUT_WIDTH-1:0] ext(input logic [IN_WIDTH-1:0] imm,
                                                 input logic [1:0]          mode);
        logic [OUT_WIDTH-1:0] sext_v;
        sext_v = {{EXT_W{imm[IN_WIDTH-1]}}, imm};
        case (mode)
            2'b00:   ext = sext_v;
            2'b01:   ext = {{EXT_W{1'b0}}, imm};
            2'b10:   ext = {imm, {EXT_W{1'b0}}};
`ifdef IMM_EXT_SHIFT2_EN
            2'b11:   ext = sext_v << 2;
`else
            2'b11:   ext = sext_v;
`endif
            default: ext = sext_v;
        endcase
    endfunction

    logic                 out_valid_r;
    logic                 skid_valid_r;
    logic                 in_ready_r;
    logic [OUT_WIDTH-1:0] out_imm_r;
    logic [OUT_WIDTH-1:0] skid_imm_r;

    logic                 accept_s;
    logic [OUT_WIDTH-1:0] ext_s;
    logic                 nxt_out_valid_s;
    logic                 nxt_skid_valid_s;
    logic                 load_out_s;
    logic                 out_from_skid_s;
    logic                 load_skid_s;

    // in_ready comes straight from a register, so out_ready never reaches it combinationally
    assign accept_s = in_valid && in_ready_r;
    assign ext_s    = ext(in_imm, in_mode);

    // Next-state and load-enable decode over the {out_valid, skid_valid} state
    always_comb begin
        nxt_out_valid_s  = out_valid_r;
        nxt_skid_valid_s = skid_valid_r;
        load_out_s       = 1'b0;
        out_from_skid_s  = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            // flush beats any transfer: valids drop, data registers keep their contents
            nxt_out_valid_s  = 1'b0;
            nxt_skid_valid_s = 1'b0;
        end else begin
            case ({out_valid_r, skid_valid_r})
                2'b00: begin
                    if (accept_s) begin
                        nxt_out_valid_s = 1'b1;
                        load_out_s      = 1'b1;
                    end else begin
                        nxt_out_valid_s = 1'b0;
                    end
                end
                2'b10: begin
                    if (out_ready && accept_s) begin
                        load_out_s = 1'b1;
                    end else if (out_ready) begin
                        nxt_out_valid_s = 1'b0;
                    end else if (accept_s) begin
                        nxt_skid_valid_s = 1'b1;
                        load_skid_s      = 1'b1;
                    end else begin
                        nxt_out_valid_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (out_ready) begin
                        nxt_skid_valid_s = 1'b0;
                        load_out_s       = 1'b1;
                        out_from_skid_s  = 1'b1;
                    end else begin
                        nxt_skid_valid_s = 1'b1;
                    end
                end
                default: begin
                    // skid valid without output valid cannot occur; recover to empty
                    nxt_out_valid_s  = 1'b0;
                    nxt_skid_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State register: both valid flags plus the registered in_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            out_valid_r  <= nxt_out_valid_s;
            skid_valid_r <= nxt_skid_valid_s;
            in_ready_r   <= !nxt_skid_valid_s;
        end
    end

    // Data registers: output stage and skid entry load only on their enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_imm_r  <= {OUT_WIDTH{1'b0}};
            skid_imm_r <= {OUT_WIDTH{1'b0}};
        end else begin
            if (load_out_s) begin
                out_imm_r <= out_from_skid_s ? skid_imm_r : ext_s;
            end
            if (load_skid_s) begin
                skid_imm_r <= ext_s;
            end
        end
    end

    // Output drive: every port is a plain register copy
    always_comb begin
        out_valid = out_valid_r;
        in_ready  = in_ready_r;
        out_imm   = out_imm_r;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (IN_WIDTH=16, OUT_WIDTH=32).
// A driver pushes the expected result of each accepted input into a queue.
// A separate monitor pops and compares it on each output handshake.
module tb_imm_extend_pipe;

    localparam int IW = 16;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_imm;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_imm;

    int            errors = 0;
    int            checks = 0;
    int            hs_count = 0;
    logic [OW-1:0] exp_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm)
    );

    // Reference: numeric meaning of each mode, computed with integer arithmetic
    function automatic logic [OW-1:0] model(input logic [IW-1:0] imm, input logic [1:0] mode);
        longint s;
        s = longint'(imm);
        if (imm[IW-1]) s = s - (longint'(1) << IW);
        case (mode)
            2'b00:   return OW'(s);
            2'b01:   return OW'(longint'(imm));
            2'b10:   return OW'(longint'(imm) << (OW - IW));
`ifdef IMM_EXT_SHIFT2_EN
            default: return OW'(s * 4);
`else
            default: return OW'(s);
`endif
        endcase
    endfunction

    task automatic check_w(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshakes plus the stall-hold rule
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_imm   = '0;
    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (prev_stall) begin
                check_b("hold_valid", out_valid, 1'b1);
                check_w("hold_data", out_imm, prev_imm);
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_imm);
                end else begin
                    check_w("scoreboard", out_imm, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_imm   = out_imm;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // One clock of stimulus; the expected value is pushed if the input will be accepted
    task automatic cycle(input logic v, input logic [IW-1:0] imm, input logic [1:0] mode,
                         input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        if (fl) exp_q.delete();
        else if (v && in_ready && !reset) exp_q.push_back(model(imm, mode));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
            n++;
        end
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = 2'b00; out_ready = 1'b0;
        #2;
        check_b("reset_out_valid", out_valid, 1'b0);
        check_b("reset_in_ready", in_ready, 1'b1);
        check_w("reset_out_imm", out_imm, 32'h0000_0000);
        @(posedge clk); #1; reset = 1'b0;

        // Modes with out_ready=1; each result is visible one cycle after accept
        cycle(1'b1, 16'h8000, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 16'h8000, 2'b01, 1'b0, 1'b1);
        check_w("mode_sign", out_imm, 32'hFFFF_8000);
        cycle(1'b1, 16'h1234, 2'b10, 1'b0, 1'b1);
        check_w("mode_zero", out_imm, 32'h0000_8000);
        cycle(1'b1, 16'hFFFF, 2'b11, 1'b0, 1'b1);
        check_w("mode_upper", out_imm, 32'h1234_0000);
        cycle(1'b1, 16'h0004, 2'b11, 1'b0, 1'b1);
`ifdef IMM_EXT_SHIFT2_EN
        check_w("mode11_ffff", out_imm, 32'hFFFF_FFFC);
`else
        check_w("mode11_ffff", out_imm, 32'hFFFF_FFFF);
`endif
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
`ifdef IMM_EXT_SHIFT2_EN
        check_w("mode11_0004", out_imm, 32'h0000_0010);
`else
        check_w("mode11_0004", out_imm, 32'h0000_0004);
`endif
        drain();

        // Backpressure: A, B fill the unit; C waits until space frees up
        cycle(1'b1, 16'h0001, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 16'h0002, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 16'hFFF0, 2'b00, 1'b0, 1'b0);
        check_b("full_in_ready", in_ready, 1'b0);
        check_w("full_head", out_imm, 32'h0000_0001);
        cycle(1'b1, 16'hFFF0, 2'b00, 1'b0, 1'b0);
        check_b("full_in_ready_hold", in_ready, 1'b0);
        cycle(1'b1, 16'hFFF0, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 16'hFFF0, 2'b00, 1'b0, 1'b1);
        check_w("bp_second", out_imm, 32'h0000_0002);
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
        check_w("bp_third", out_imm, 32'hFFFF_FFF0);
        drain();

        // Streaming: 8 back-to-back inputs, 8 outputs on consecutive cycles
        begin
            int hs0;
            hs0 = hs_count;
            for (int i = 0; i < 8; i++) begin
                cycle(1'b1, IW'($urandom), 2'($urandom), 1'b0, 1'b1);
                check_b("stream_in_ready", in_ready, 1'b1);
                if (i > 0) check_b("stream_out_valid", out_valid, 1'b1);
            end
            cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
            check_b("stream_last_valid", out_valid, 1'b1);
            cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
            check_w("stream_count", 32'(hs_count - hs0), 32'd8);
        end
        drain();

        // Flush in FULL with a live input: everything held and presented is dropped
        cycle(1'b1, 16'h0AAA, 2'b01, 1'b0, 1'b0);
        cycle(1'b1, 16'h0BBB, 2'b01, 1'b0, 1'b0);
        cycle(1'b1, 16'h0CCC, 2'b01, 1'b1, 1'b0);
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b0);
        check_b("flush_out_valid", out_valid, 1'b0);
        check_b("flush_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
        check_b("flush_nothing_emerges", out_valid, 1'b0);

        // Randomized traffic with random backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), IW'($urandom), 2'($urandom),
                  ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, 1'($urandom));
        end
        drain();

        // Asynchronous reset between edges while in ONE
        cycle(1'b1, 16'h5555, 2'b01, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check_b("pre_reset_one", out_valid, 1'b1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_b("async_rst_out_valid", out_valid, 1'b0);
        check_b("async_rst_in_ready", in_ready, 1'b1);
        check_w("async_rst_out_imm", out_imm, 32'h0000_0000);
        @(posedge clk); #1; reset = 1'b0;
        cycle(1'b1, 16'h7FFF, 2'b00, 1'b0, 1'b1);
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b1);
        check_w("post_reset", out_imm, 32'h0000_7FFF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
